// File: rtl/posit_mac_seq_if.sv
// posit_mac_seq_if -- bundle of all non-clock/reset signals of posit_mac_seq.
//   Command : START, USE_BIAS, BIAS_IN, ABORT
//   Stream  : S_VALID, S_READY, S_A, S_B, S_LAST
//   MAC pins: IN1, IN2, BIAS, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS, MAC_OUT
//   Result  : RES, RES_CNT, RES_VALID, RES_READY
//   Status  : BUSY
// master = environment side (producer, MAC, result consumer); slave = sequencer.
interface posit_mac_seq_if #(
    parameter int N     = 8,
    parameter int LEN_W = 10
);
    logic             START;
    logic             USE_BIAS;
    logic [N-1:0]     BIAS_IN;
    logic             ABORT;
    logic             S_VALID;
    logic             S_READY;
    logic [N-1:0]     S_A;
    logic [N-1:0]     S_B;
    logic             S_LAST;
    logic [N-1:0]     IN1;
    logic [N-1:0]     IN2;
    logic [N-1:0]     BIAS;
    logic             MAC_EN;
    logic             PURGE;
    logic             BIAS_EN;
    logic             RESULT_REQ_PLS;
    logic [N-1:0]     MAC_OUT;
    logic [N-1:0]     RES;
    logic [LEN_W-1:0] RES_CNT;
    logic             RES_VALID;
    logic             RES_READY;
    logic             BUSY;

    modport master (
        output START, USE_BIAS, BIAS_IN, ABORT, S_VALID, S_A, S_B, S_LAST,
               MAC_OUT, RES_READY,
        input  S_READY, IN1, IN2, BIAS, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS,
               RES, RES_CNT, RES_VALID, BUSY
    );

    modport slave (
        input  START, USE_BIAS, BIAS_IN, ABORT, S_VALID, S_A, S_B, S_LAST,
               MAC_OUT, RES_READY,
        output S_READY, IN1, IN2, BIAS, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS,
               RES, RES_CNT, RES_VALID, BUSY
    );
endinterface

// File: rtl/posit_mac_seq.sv
// posit_mac_seq -- operand sequencer in front of an N-bit es=0 posit MAC.
// Takes one dot-product job at a time (START + optional bias, then a
// valid/ready stream of operand pairs ending on S_LAST), drives the MAC
// control pins, and captures the rounded MAC output into a held result
// register with a valid/ready handshake.
//
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-low reset; all outputs 0, state IDLE
//   bus    - posit_mac_seq_if.slave (command, stream, MAC pins, result, BUSY)
// Parameters:
//   N       - posit width (must match the interface)
//   LEN_W   - pair counter width (saturating)
//   MAC_LAT - MAC latency from the RESULT_REQ_PLS cycle to OUT valid, 1..15
// Build option:
//   POSIT_SEQ_ZERO_SKIP_EN - when defined, pairs with a zero operand (and no
//   NaR operand) are consumed and counted but do not raise MAC_EN.
module posit_mac_seq #(
    parameter int N       = 8,
    parameter int LEN_W   = 10,
    parameter int MAC_LAT = 3
) (
    input logic            CLK,
    input logic            RESET,
    posit_mac_seq_if.slave bus
);
    localparam int            WCNT_W = 4;
    localparam logic [N-1:0]  NAR    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLR, ST_LDB, ST_STRM, ST_REQ, ST_WAIT, ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               use_bias_q, abort_q;
    logic [N-1:0]       bias_q, in1_q, in2_q, res_q;
    logic               mac_en_q, purge_q, bias_en_q, req_q;
    logic               s_ready_q, res_valid_q, busy_q;
    logic [LEN_W-1:0]   cnt_q, res_cnt_q;
    logic [WCNT_W-1:0]  wcnt_q;

    logic hs, abort_go, skip, cnt_sat;

    assign hs       = s_ready_q & bus.S_VALID;
    assign abort_go = bus.ABORT & (state_q != ST_IDLE);
    assign cnt_sat  = &cnt_q;

`ifdef POSIT_SEQ_ZERO_SKIP_EN
    // A zero product contributes nothing, but NaR must still reach the quire.
    assign skip = ((bus.S_A == '0) || (bus.S_B == '0)) &&
                  (bus.S_A != NAR) && (bus.S_B != NAR);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (abort_go) begin
            state_d = ST_CLR;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.START) state_d = ST_CLR;
                // abort_q marks a cancel purge: no bias load, straight to IDLE
                ST_CLR:  state_d = abort_q ? ST_IDLE : (use_bias_q ? ST_LDB : ST_STRM);
                ST_LDB:  state_d = ST_STRM;
                ST_STRM: if (hs && bus.S_LAST) state_d = ST_REQ;
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: if (wcnt_q == '0) state_d = ST_HOLD;
                ST_HOLD: if (bus.RES_READY) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            use_bias_q  <= 1'b0;
            abort_q     <= 1'b0;
            bias_q      <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            res_q       <= '0;
            mac_en_q    <= 1'b0;
            purge_q     <= 1'b0;
            bias_en_q   <= 1'b0;
            req_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            res_cnt_q   <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            // Control outputs are decoded from the next state so they are
            // registered yet line up with the state they belong to.
            purge_q     <= (state_d == ST_CLR);
            bias_en_q   <= (state_d == ST_LDB);
            s_ready_q   <= (state_d == ST_STRM);
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_HOLD);
            // REQ state is the cycle of the final MAC_EN; the round request
            // goes out in the following cycle, on the way into WAIT.
            req_q       <= (state_q == ST_REQ) && !abort_go;
            mac_en_q    <= hs && !abort_go && !skip;

            if (abort_go)
                abort_q <= 1'b1;
            else if (state_q == ST_CLR)
                abort_q <= 1'b0;

            if (state_q == ST_IDLE && bus.START) begin
                use_bias_q <= bus.USE_BIAS;
                bias_q     <= bus.BIAS_IN;
                cnt_q      <= '0;
            end

            if (hs && !abort_go) begin
                in1_q <= bus.S_A;
                in2_q <= bus.S_B;
                if (!cnt_sat)
                    cnt_q <= cnt_q + 1'b1;
            end

            // Loaded with MAC_LAT (not MAC_LAT-1) because the request pulse
            // itself occupies the first WAIT cycle; capture then samples OUT
            // in the MAC_LAT-th cycle after the pulse.
            if (state_q == ST_REQ)
                wcnt_q <= WCNT_W'(MAC_LAT);
            else if (state_q == ST_WAIT && wcnt_q != '0)
                wcnt_q <= wcnt_q - 1'b1;

            if (state_q == ST_WAIT && state_d == ST_HOLD) begin
                res_q     <= bus.MAC_OUT;
                res_cnt_q <= cnt_q;
            end
        end
    end

    assign bus.S_READY        = s_ready_q;
    assign bus.IN1            = in1_q;
    assign bus.IN2            = in2_q;
    assign bus.BIAS           = bias_q;
    assign bus.MAC_EN         = mac_en_q;
    assign bus.PURGE          = purge_q;
    assign bus.BIAS_EN        = bias_en_q;
    assign bus.RESULT_REQ_PLS = req_q;
    assign bus.RES            = res_q;
    assign bus.RES_CNT        = res_cnt_q;
    assign bus.RES_VALID      = res_valid_q;
    assign bus.BUSY           = busy_q;
endmodule
